// File: rtl/phy_rx_if.sv
// USB full-speed receive bus between the line interface and the packet layer.
// Ports: dp_rx_i/dn_rx_i raw D+/D-, rx_en_i receiver enable (low while
//   transmitting), rx_valid_o packet in progress, rx_ready_o new-byte strobe,
//   rx_data_o last received byte, rx_err_o error strobe.
// master = receiver (drives rx_*_o), slave = consumer (drives line and enable).
interface phy_rx_if;
    logic       dp_rx_i;
    logic       dn_rx_i;
    logic       rx_en_i;
    logic       rx_valid_o;
    logic       rx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_err_o;

    modport master (
        input  dp_rx_i,
        input  dn_rx_i,
        input  rx_en_i,
        output rx_valid_o,
        output rx_ready_o,
        output rx_data_o,
        output rx_err_o
    );

    modport slave (
        output dp_rx_i,
        output dn_rx_i,
        output rx_en_i,
        input  rx_valid_o,
        input  rx_ready_o,
        input  rx_data_o,
        input  rx_err_o
    );
endinterface

// File: rtl/phy_rx.sv
// USB full-speed receiver: line sync, clock recovery, NRZI decode,
// bit unstuffing, sync/EOP detection and byte assembly.
// Ports: clk_i clock (12MHz*BIT_SAMPLES), rst_i sync active-high reset,
//   bus (phy_rx_if.master) carrying line inputs, enable and rx outputs.
module phy_rx #(
    parameter int BIT_SAMPLES = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    phy_rx_if.master bus
);

    localparam int CW = $clog2(BIT_SAMPLES);
    localparam logic [CW-1:0] CNT_MID = CW'(BIT_SAMPLES / 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(BIT_SAMPLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP   = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    // line encoding {dp, dn}
    localparam logic [1:0] LN_J = 2'b10;

    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    state_q, state_d;
    logic          nrzi_j_q, nrzi_j_d;
    logic [1:0]    zcnt_q, zcnt_d;
    logic [2:0]    stuff_q, stuff_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          partial_q, partial_d;
    logic          se0_seen_q, se0_seen_d;
    logic [2:0]    jcnt_q, jcnt_d;

    logic is_j, is_k, is_se0, is_se1;
    logic sample, line_edge, dec_bit;

    assign is_j   = (sync2_q == 2'b10);
    assign is_k   = (sync2_q == 2'b01);
    assign is_se0 = (sync2_q == 2'b00);
    assign is_se1 = (sync2_q == 2'b11);

    // s2 is about to take a new value: restart the bit phase on that edge
    assign line_edge = (sync1_q != sync2_q);
    assign sample    = (cnt_q == CNT_MID);
    // NRZI: no transition means 1
    assign dec_bit   = (is_j == nrzi_j_q);

    always_comb begin
        sync1_d    = {bus.dp_rx_i, bus.dn_rx_i};
        sync2_d    = sync1_q;
        cnt_d      = (line_edge || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        state_d    = state_q;
        nrzi_j_d   = nrzi_j_q;
        zcnt_d     = zcnt_q;
        stuff_d    = stuff_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        partial_d  = partial_q;
        se0_seen_d = se0_seen_q;
        jcnt_d     = jcnt_q;

        if (sample && (is_j || is_k)) begin
            nrzi_j_d = is_j;
        end

        case (state_q)
            ST_IDLE: begin
                valid_d    = 1'b0;
                stuff_d    = 3'd0;
                partial_d  = 1'b0;
                se0_seen_d = 1'b0;
                jcnt_d     = 3'd0;
                // the first K is the first sync zero
                if (sample && is_k) begin
                    state_d = ST_SYNC;
                    zcnt_d  = 2'd1;
                end
            end
            ST_SYNC: begin
                if (sample) begin
                    unique case (1'b1)
                        is_j, is_k: begin
                            if (!dec_bit) begin
                                if (zcnt_q != 2'd3) begin
                                    zcnt_d = zcnt_q + 2'd1;
                                end
                            end else if (zcnt_q == 2'd3) begin
                                state_d = ST_DATA;
                                valid_d = 1'b1;
                                stuff_d = 3'd0;
                                bcnt_d  = 3'd0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        is_se0, is_se1: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_DATA: begin
                if (sample) begin
                    unique case (1'b1)
                        is_se0: begin
                            state_d   = ST_EOP;
                            partial_d = (bcnt_q != 3'd0);
                        end
                        is_se1: begin
                            state_d = ST_ABORT;
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                        end
                        is_j, is_k: begin
                            if (stuff_q == 3'd6) begin
                                // post-stuff bit: must be 0, never data
                                stuff_d = 3'd0;
                                if (dec_bit) begin
                                    state_d = ST_ABORT;
                                    valid_d = 1'b0;
                                    err_d   = 1'b1;
                                end
                            end else begin
                                stuff_d = dec_bit ? stuff_q + 3'd1 : 3'd0;
                                shift_d = {dec_bit, shift_q[7:1]};
                                bcnt_d  = bcnt_q + 3'd1;
                                if (bcnt_q == 3'd7) begin
                                    data_d  = {dec_bit, shift_q[7:1]};
                                    ready_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_EOP: begin
                if (sample) begin
                    unique case (1'b1)
                        is_j: begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            err_d   = partial_q;
                        end
                        is_k, is_se1: begin
                            state_d = ST_ABORT;
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                        end
                        is_se0: state_d = ST_EOP;
                    endcase
                end
            end
            ST_ABORT: begin
                valid_d = 1'b0;
                if (sample) begin
                    unique case (1'b1)
                        is_se0: begin
                            se0_seen_d = 1'b1;
                            jcnt_d     = 3'd0;
                        end
                        is_j: begin
                            jcnt_d = jcnt_q + 3'd1;
                            if (se0_seen_q || jcnt_q == 3'd7) begin
                                state_d = ST_IDLE;
                            end
                        end
                        is_k, is_se1: begin
                            se0_seen_d = 1'b0;
                            jcnt_d     = 3'd0;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // transmitter owns the bus: drop everything except the last byte
        if (!bus.rx_en_i) begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            ready_d  = 1'b0;
            err_d    = 1'b0;
            nrzi_j_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= LN_J;
            sync2_q    <= LN_J;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            nrzi_j_q   <= 1'b1;
            zcnt_q     <= 2'd0;
            stuff_q    <= 3'd0;
            bcnt_q     <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            partial_q  <= 1'b0;
            se0_seen_q <= 1'b0;
            jcnt_q     <= 3'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            nrzi_j_q   <= nrzi_j_d;
            zcnt_q     <= zcnt_d;
            stuff_q    <= stuff_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            partial_q  <= partial_d;
            se0_seen_q <= se0_seen_d;
            jcnt_q     <= jcnt_d;
        end
    end

    assign bus.rx_valid_o = valid_q;
    assign bus.rx_ready_o = ready_q;
    assign bus.rx_data_o  = data_q;
    assign bus.rx_err_o   = err_q;

endmodule

// File: tb/tb_phy_rx.sv
// Directed bench for phy_rx: NRZI/stuffing line encoder, byte scoreboard,
// strobe counters checked against expected deltas per packet.
module tb_phy_rx;

    localparam int BS = 4;

    logic clk_i = 1'b0;
    logic rst_i;

    phy_rx_if bus ();

    phy_rx #(.BIT_SAMPLES(BS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int rdy_seen = 0;
    int err_seen = 0;
    int r0, e0;

    logic [7:0] sb[$];
    logic [7:0] exp_b;
    logic       lvl;
    int         ones;
    bit         alt_mode;
    bit         alt_ph;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // output monitor: pops the scoreboard on every byte strobe
    always @(negedge clk_i) begin
        if (bus.rx_ready_o) begin
            rdy_seen++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_empty observed=%0h expected=none",
                       bus.rx_data_o);
            end
            if (sb.size() > 0) begin
                exp_b = sb.pop_front();
                checks++;
                assert (bus.rx_data_o === exp_b) else begin
                    errors++;
                    $error("FAIL rx_data observed=%0h expected=%0h",
                           bus.rx_data_o, exp_b);
                end
            end
        end
        if (bus.rx_err_o) err_seen++;
        if (bus.rx_ready_o || bus.rx_err_o) begin
            checks++;
            assert (!(bus.rx_ready_o && bus.rx_err_o)) else begin
                errors++;
                $error("FAIL rdy_err_overlap observed=1 expected=0");
            end
        end
    end

    task automatic drive(input logic dp, input logic dn, input int n);
        bus.dp_rx_i = dp;
        bus.dn_rx_i = dn;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // one NRZI bit time: 0 toggles the line, 1 holds it
    task automatic line_bit(input logic b);
        int per;
        if (!b) lvl = ~lvl;
        if (alt_mode) begin
            alt_ph = ~alt_ph;
            per = alt_ph ? BS + 1 : BS - 1;
        end else begin
            per = BS;
        end
        drive(lvl, ~lvl, per);
    endtask

    task automatic data_bit(input logic b);
        line_bit(b);
        if (b) ones++;
        else ones = 0;
        if (ones == 6) begin
            line_bit(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) line_bit(1'b0);
        line_bit(1'b1);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sb.push_back(b);
        for (int i = 0; i < 8; i++) data_bit(b[i]);
    endtask

    task automatic send_eop();
        drive(1'b0, 1'b0, 2 * BS);
        lvl = 1'b1;
        drive(1'b1, 1'b0, BS);
        drive(1'b1, 1'b0, 4 * BS);
    endtask

    task automatic mark();
        r0 = rdy_seen;
        e0 = err_seen;
    endtask

    initial begin
        rst_i = 1'b1;
        bus.dp_rx_i = 1'b1;
        bus.dn_rx_i = 1'b0;
        bus.rx_en_i = 1'b1;
        lvl = 1'b1;
        ones = 0;
        alt_mode = 1'b0;
        alt_ph = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_valid", 32'(bus.rx_valid_o), 0);
        chk("rst_ready", 32'(bus.rx_ready_o), 0);
        chk("rst_err", 32'(bus.rx_err_o), 0);
        chk("rst_data", 32'(bus.rx_data_o), 32'h00);
        drive(1'b1, 1'b0, 4 * BS);

        // basic packet
        mark();
        send_sync();
        send_byte(8'hA5);
        chk("a5_valid_mid", 32'(bus.rx_valid_o), 1);
        send_eop();
        chk("a5_ready_cnt", 32'(rdy_seen - r0), 1);
        chk("a5_err_cnt", 32'(err_seen - e0), 0);
        chk("a5_valid_end", 32'(bus.rx_valid_o), 0);
        chk("a5_data", 32'(bus.rx_data_o), 32'hA5);

        // stuffed zero after six ones
        mark();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        send_eop();
        chk("stuff_ready_cnt", 32'(rdy_seen - r0), 2);
        chk("stuff_err_cnt", 32'(err_seen - e0), 0);
        chk("stuff_data", 32'(bus.rx_data_o), 32'h01);

        // seven ones, stuff bit missing
        mark();
        send_sync();
        for (int i = 0; i < 7; i++) line_bit(1'b1);
        drive(lvl, ~lvl, 2 * BS);
        chk("nostuff_valid", 32'(bus.rx_valid_o), 0);
        chk("nostuff_err_cnt", 32'(err_seen - e0), 1);
        send_eop();
        chk("nostuff_ready_cnt", 32'(rdy_seen - r0), 0);
        chk("nostuff_err_end", 32'(err_seen - e0), 1);

        // EOP after three data bits
        mark();
        send_sync();
        data_bit(1'b1);
        data_bit(1'b0);
        data_bit(1'b1);
        send_eop();
        chk("partial_ready_cnt", 32'(rdy_seen - r0), 0);
        chk("partial_err_cnt", 32'(err_seen - e0), 1);
        chk("partial_valid", 32'(bus.rx_valid_o), 0);

        // bit periods alternately stretched and shrunk by one clk
        mark();
        alt_mode = 1'b1;
        alt_ph = 1'b0;
        send_sync();
        send_byte(8'h3C);
        send_byte(8'hC3);
        send_byte(8'h96);
        send_byte(8'h5A);
        alt_mode = 1'b0;
        send_eop();
        chk("jitter_ready_cnt", 32'(rdy_seen - r0), 4);
        chk("jitter_err_cnt", 32'(err_seen - e0), 0);

        // receiver disabled mid-byte
        mark();
        send_sync();
        for (int i = 0; i < 4; i++) data_bit(i[0]);
        bus.rx_en_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("en_valid", 32'(bus.rx_valid_o), 0);
        chk("en_ready", 32'(bus.rx_ready_o), 0);
        chk("en_err", 32'(bus.rx_err_o), 0);
        chk("en_data_hold", 32'(bus.rx_data_o), 32'h5A);
        lvl = 1'b1;
        ones = 0;
        drive(1'b1, 1'b0, 4 * BS);
        bus.rx_en_i = 1'b1;
        drive(1'b1, 1'b0, 4 * BS);
        send_sync();
        send_byte(8'h3A);
        send_eop();
        chk("en_ready_cnt", 32'(rdy_seen - r0), 1);
        chk("en_err_cnt", 32'(err_seen - e0), 0);

        // reset mid-byte
        mark();
        send_sync();
        for (int i = 0; i < 4; i++) data_bit(i[0]);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("mrst_valid", 32'(bus.rx_valid_o), 0);
        chk("mrst_ready", 32'(bus.rx_ready_o), 0);
        chk("mrst_err", 32'(bus.rx_err_o), 0);
        chk("mrst_data", 32'(bus.rx_data_o), 32'h00);
        rst_i = 1'b0;
        lvl = 1'b1;
        ones = 0;
        drive(1'b1, 1'b0, 4 * BS);
        send_sync();
        send_byte(8'hC5);
        send_eop();
        chk("mrst_ready_cnt", 32'(rdy_seen - r0), 1);
        chk("mrst_err_cnt", 32'(err_seen - e0), 0);
        chk("mrst_data_end", 32'(bus.rx_data_o), 32'hC5);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_rx.md
PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 The module SHALL have parameter BIT_SAMPLES, default 4, giving clk_i cycles per USB bit (clk_i = 12MHz*BIT_SAMPLES); legal values are even and >= 4.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port dp_rx_i, input, 1 bit: asynchronous D+ line.
REQ-005 The module SHALL have port dn_rx_i, input, 1 bit: asynchronous D- line.
REQ-006 The module SHALL have port rx_en_i, input, 1 bit: receiver enable; it is low while the local transmitter drives the bus.
REQ-007 The module SHALL have port rx_valid_o, output, 1 bit: packet in progress, high from sync accepted until end of packet.
REQ-008 The module SHALL have port rx_ready_o, output, 1 bit: one-clk strobe marking that rx_data_o holds a new byte.
REQ-009 The module SHALL have port rx_data_o, output, 8 bits: last received byte, LSB received first.
REQ-010 The module SHALL have port rx_err_o, output, 1 bit: one-clk strobe on a stuffing, alignment or line-state error.

Function
REQ-011 dp_rx_i/dn_rx_i SHALL pass through a 2-flop synchronizer; line states: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
REQ-012 Clock recovery SHALL use a sample counter 0..BIT_SAMPLES-1: reset to 0 on the clk where the synchronized line state changes, otherwise increment with wrap; the bit is sampled when counter == BIT_SAMPLES/2.
REQ-013 NRZI decode SHALL give bit 0 when the sampled state differs from the previous sampled J/K state and bit 1 when it is equal; the previous state resets to J.
REQ-014 FSM states SHALL be ST_IDLE, ST_SYNC, ST_DATA, ST_EOP and ST_ABORT; the reset state is ST_IDLE.
REQ-015 ST_IDLE: a sampled K SHALL move to ST_SYNC and counts as the first sync 0 bit.
REQ-016 ST_SYNC: sync SHALL be accepted on a decoded 1 after >= 3 consecutive decoded 0s; on acceptance go to ST_DATA and raise rx_valid_o on the next clk.
REQ-017 ST_SYNC: a 1 after fewer than 3 zeros, or a sampled SE0, SHALL return to ST_IDLE with no rx_valid_o and no rx_err_o.
REQ-018 ST_DATA: decoded bits SHALL shift in LSB first; after 8 data bits, rx_data_o updates and rx_ready_o pulses for exactly one clk in the same cycle.
REQ-019 Bit unstuffing: after six consecutive decoded 1s (counted across byte boundaries), the next bit SHALL be discarded if 0.
REQ-020 If that post-stuff bit is 1, rx_err_o SHALL pulse once and the FSM SHALL go to ST_ABORT.
REQ-021 ST_DATA: a sampled SE0 SHALL go to ST_EOP; a sampled SE1 SHALL pulse rx_err_o and go to ST_ABORT.
REQ-022 ST_EOP: a sampled J SHALL go to ST_IDLE and deassert rx_valid_o.
REQ-023 ST_EOP: if the bit count within the current byte was nonzero at SE0, rx_err_o SHALL pulse on EOP completion; a sampled K SHALL pulse rx_err_o and go to ST_ABORT.
REQ-024 ST_ABORT: rx_valid_o SHALL be 0; the FSM SHALL go to ST_IDLE after a sampled SE0 followed by J, or after 8 consecutive J bit times.
REQ-025 The stuffing counter SHALL reset to 0 on any decoded 0, in ST_IDLE, and on sync acceptance.
REQ-026 While rx_en_i is 0, the FSM SHALL be forced to ST_IDLE, rx_valid_o/rx_ready_o/rx_err_o held 0, and the NRZI previous state set to J; rx_data_o SHALL hold its value.
REQ-027 Latency: rx_ready_o SHALL assert no more than BIT_SAMPLES+3 clk after the line edge of the last bit of a byte (2 sync plus sample point).
REQ-028 rx_ready_o and rx_err_o SHALL never assert in the same clk; an error in the bit that completes a byte suppresses that byte's rx_ready_o.

Reset
REQ-029 On clk_i rising edge with rst_i = 1: FSM ST_IDLE, rx_valid_o = 0, rx_ready_o = 0, rx_err_o = 0, rx_data_o = 8'h00, sample counter 0, stuffing counter 0, NRZI previous state J, synchronizer flops J.
REQ-030 Reset asserted mid-packet SHALL take effect on the next clk, discarding any partial byte with no rx_ready_o or rx_err_o.

Verification
REQ-031 Bench SHALL cover: sync KJKJKJKK, then byte 8'hA5, then SE0 SE0 J -> exactly one rx_ready_o with rx_data_o = 8'hA5, rx_valid_o drops after J.
REQ-032 Bench SHALL cover: byte 8'hFF followed by 8'h01 with the stuffed 0 inserted -> rx_data_o 8'hFF then 8'h01, no rx_err_o.
REQ-033 Bench SHALL cover: seven consecutive decoded 1s with no stuff bit -> one rx_err_o, rx_valid_o = 0, no further rx_ready_o until the next packet.
REQ-034 Bench SHALL cover: SE0 after 3 data bits -> rx_err_o on EOP completion, no rx_ready_o for the partial byte.
REQ-035 Bench SHALL cover: a packet sent with each bit period stretched/shrunk by one clk (BIT_SAMPLES = 4) -> all bytes correct, which proves edge resync.
REQ-036 Bench SHALL cover: rx_en_i = 0 or rst_i = 1 mid-byte -> all strobes 0 next clk; the following clean packet decodes correctly.
